// File: rtl/keypad_entry.sv
// keypad_entry
//   Front end of the calculator datapath. Turns single key events into a
//   token stream (operands, operators, equals marker) for the ALU/mux stage,
//   limits each operand to MAX_DIGITS decimal digits and each expression to
//   MAX_OPERANDS operands, and shows the value being typed on cur_value.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   key_valid    key event present
//   key_code     0-9 digit, 10 ADD, 11 SUB, 12 NEG, 13 EQ, 14 CLR, 15 BKSP
//   key_ready    stage accepts a key this cycle (only while entering)
//   out_valid    token present
//   out_ready    downstream accepts the token
//   out_kind     0 operand, 1 operator, 2 equals
//   out_data     operand value, operator code in bit 0 (0 ADD, 1 SUB), or 0
//   cur_value    signed value currently being entered
//   digit_count  digits in the current entry
//   err          one-cycle pulse, the cycle after a rejected key
//   fsm_state    debug view of the FSM (0 ENTRY, 1 EMIT_OPND, 2 EMIT_OP, 3 EMIT_EQ)
//
// Handshake: a key moves when key_valid && key_ready on a rising edge; a
// token moves when out_valid && out_ready on a rising edge. While out_valid
// is high, out_kind/out_data stay constant until that transfer happens.
module keypad_entry #(
   parameter int WIDTH        = 11,
   parameter int MAX_DIGITS   = 3,
   parameter int MAX_OPERANDS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic             key_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_kind,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] cur_value,
   output logic [1:0]       digit_count,
   output logic             err,
   output logic [1:0]       fsm_state
);

   localparam int MW = WIDTH - 1;
   localparam logic [1:0] DIGIT_LIMIT = 2'(MAX_DIGITS);
   localparam logic [1:0] OPND_LIMIT  = 2'(MAX_OPERANDS - 1);

   typedef enum logic [1:0] {
      ENTRY     = 2'd0,
      EMIT_OPND = 2'd1,
      EMIT_OP   = 2'd2,
      EMIT_EQ   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [MW-1:0]   mag;
   logic            sign;
   logic [1:0]      dc;
   logic [1:0]      opnd_cnt;
   logic            op_sub;
   logic            pend_eq;     // operand token is followed by EQ, not an operator
   logic [WIDTH-1:0] mag_ext;

   // key decode
   logic key_fire, out_fire;
   logic is_digit, is_op, is_neg, is_eq, is_clr, is_bksp;
   logic digit_ok, op_ok, eq_ok, reject;

   always_comb begin
      key_fire = key_valid && key_ready;
      out_fire = out_valid && out_ready;
      is_digit = key_code < 4'd10;
      is_op    = (key_code == 4'd10) || (key_code == 4'd11);
      is_neg   = key_code == 4'd12;
      is_eq    = key_code == 4'd13;
      is_clr   = key_code == 4'd14;
      is_bksp  = key_code == 4'd15;
      digit_ok = dc < DIGIT_LIMIT;
      op_ok    = (dc != 2'd0) && (opnd_cnt != OPND_LIMIT);
      // An empty entry after an operator still ends with a (zero) operand.
      eq_ok    = (dc != 2'd0) || (opnd_cnt != 2'd0);
      reject   = key_fire && ((is_digit && !digit_ok) ||
                              (is_op && !op_ok) ||
                              (is_eq && !eq_ok));
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ENTRY;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ENTRY: begin
            if (key_fire && ((is_op && op_ok) || (is_eq && eq_ok)))
               state_nxt = EMIT_OPND;
         end
         EMIT_OPND: begin
            if (out_fire) state_nxt = pend_eq ? EMIT_EQ : EMIT_OP;
         end
         EMIT_OP, EMIT_EQ: begin
            if (out_fire) state_nxt = ENTRY;
         end
         default: state_nxt = ENTRY;
      endcase
   end

   // entry datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         mag      <= '0;
         sign     <= 1'b0;
         dc       <= 2'd0;
         opnd_cnt <= 2'd0;
         op_sub   <= 1'b0;
         pend_eq  <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= reject;
         case (state)
            ENTRY: begin
               if (key_fire) begin
                  if (is_digit) begin
                     if (digit_ok) begin
                        mag <= mag * MW'(10) + MW'(key_code);
                        dc  <= dc + 2'd1;
                     end
                  end else if (is_op) begin
                     if (op_ok) begin
                        op_sub  <= key_code[0];
                        pend_eq <= 1'b0;
                     end
                  end else if (is_neg) begin
                     sign <= ~sign;
                  end else if (is_eq) begin
                     if (eq_ok) pend_eq <= 1'b1;
                  end else if (is_clr) begin
                     mag      <= '0;
                     sign     <= 1'b0;
                     dc       <= 2'd0;
                     opnd_cnt <= 2'd0;
                  end else if (is_bksp) begin
                     if (dc != 2'd0) begin
                        mag <= mag / MW'(10);
                        dc  <= dc - 2'd1;
                        if (dc == 2'd1) sign <= 1'b0;
                     end
                  end
               end
            end
            EMIT_OP: begin
               if (out_fire) begin
                  mag      <= '0;
                  sign     <= 1'b0;
                  dc       <= 2'd0;
                  opnd_cnt <= opnd_cnt + 2'd1;
               end
            end
            EMIT_EQ: begin
               if (out_fire) begin
                  mag      <= '0;
                  sign     <= 1'b0;
                  dc       <= 2'd0;
                  opnd_cnt <= 2'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // Negating a zero magnitude yields zero, so a tracked sign on an empty
   // entry never shows up as negative zero.
   always_comb begin
      mag_ext   = {1'b0, mag};
      cur_value = sign ? (~mag_ext + WIDTH'(1)) : mag_ext;
   end

   // outputs; all derived from registered state, so they hold while stalled
   always_comb begin
      key_ready   = (state == ENTRY);
      out_valid   = (state != ENTRY);
      out_kind    = 2'd0;
      out_data    = '0;
      digit_count = dc;
      fsm_state   = state;
      case (state)
         EMIT_OPND: begin
            out_kind = 2'd0;
            out_data = cur_value;
         end
         EMIT_OP: begin
            out_kind = 2'd1;
            out_data = {{(WIDTH-1){1'b0}}, op_sub};
         end
         EMIT_EQ: begin
            out_kind = 2'd2;
            out_data = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: key sequences with hand-computed tokens
// and display values.
module tb_keypad_entry;

   localparam int WIDTH = 11;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             key_valid = 1'b0;
   logic [3:0]       key_code  = 4'd0;
   logic             key_ready;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [1:0]       out_kind;
   logic [WIDTH-1:0] out_data;
   logic [WIDTH-1:0] cur_value;
   logic [1:0]       digit_count;
   logic             err;
   logic [1:0]       fsm_state;

   keypad_entry #(.WIDTH(WIDTH), .MAX_DIGITS(3), .MAX_OPERANDS(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_kind    (out_kind),
      .out_data    (out_data),
      .cur_value   (cur_value),
      .digit_count (digit_count),
      .err         (err),
      .fsm_state   (fsm_state)
   );

   localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_NEG = 4'd12,
                          K_EQ = 4'd13, K_CLR = 4'd14, K_BKSP = 4'd15;

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard: {kind, data}
   logic [12:0] exp_q[$];
   logic [12:0] obs_q[$];

   always @(posedge clk) begin
      if (out_valid && out_ready) obs_q.push_back({out_kind, out_data});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive one key and hold it until it is consumed
   task automatic press(input logic [3:0] c);
      int i;
      key_valid = 1'b1;
      key_code  = c;
      i = 0;
      while (!key_ready && i < 50) begin
         tick();
         i++;
      end
      if (i >= 50) check("press_timeout", 32'(key_ready), 32'd1);
      tick();
      key_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         if (key_ready) break;
         tick();
      end
      check("idle_timeout", 32'(key_ready), 32'd1);
   endtask

   task automatic exp_tok(input logic [1:0] kind, input logic [WIDTH-1:0] data);
      exp_q.push_back({kind, data});
   endtask

   task automatic check_tokens(input string tag);
      logic [12:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) check({tag, "_missing"}, 32'hDEAD, 32'(e));
         else                   check(tag, 32'(obs_q.pop_front()), 32'(e));
      end
      check({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
   endtask

   initial begin
      // reset
      repeat (2) tick();
      rst = 1'b0;
      check("rst_cur", 32'(cur_value), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_key_ready", 32'(key_ready), 32'd1);
      check("rst_err", 32'(err), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);

      // 123 ADD 45 EQ, including latency of the operator key
      press(4'd1); press(4'd2); press(4'd3);
      check("cur_123", 32'(cur_value), 32'd123);
      check("dc_3", 32'(digit_count), 32'd3);
      press(K_ADD);
      check("lat_n1_valid", 32'(out_valid), 32'd1);
      check("lat_n1_tok", 32'({out_kind, out_data}), 32'({2'd0, 11'd123}));
      check("lat_n1_kready", 32'(key_ready), 32'd0);
      tick();
      check("lat_n2_tok", 32'({out_kind, out_data}), 32'({2'd1, 11'd0}));
      check("lat_n2_kready", 32'(key_ready), 32'd0);
      tick();
      check("lat_n3_kready", 32'(key_ready), 32'd1);
      check("after_op_cur", 32'(cur_value), 32'd0);
      press(4'd4); press(4'd5); press(K_EQ);
      wait_idle();
      exp_tok(2'd0, 11'd123); exp_tok(2'd1, 11'd0);
      exp_tok(2'd0, 11'd45);  exp_tok(2'd2, 11'd0);
      check_tokens("tok_123_45");

      // digit limit, sign, backspace
      press(4'd9); press(4'd9); press(4'd9);
      check("cur_999", 32'(cur_value), 32'd999);
      check("no_err_3rd", 32'(err), 32'd0);
      press(4'd9);
      check("err_4th_digit", 32'(err), 32'd1);
      check("cur_still_999", 32'(cur_value), 32'd999);
      tick();
      check("err_one_cycle", 32'(err), 32'd0);
      press(K_NEG);
      check("cur_neg999", 32'(cur_value), 32'h419);
      press(K_BKSP);
      check("cur_neg99", 32'(cur_value), 32'h79D);
      check("dc_after_bksp", 32'(digit_count), 32'd2);
      press(K_CLR);
      check("clr_cur", 32'(cur_value), 32'd0);
      check("clr_dc", 32'(digit_count), 32'd0);

      // downstream stall holds the operand token
      out_ready = 1'b0;
      press(4'd7); press(K_ADD);
      key_valid = 1'b1;
      key_code  = 4'd1;
      for (int i = 0; i < 5; i++) begin
         check("stall_tok", 32'({out_valid, out_kind, out_data}), 32'({1'b1, 2'd0, 11'd7}));
         check("stall_kready", 32'(key_ready), 32'd0);
         tick();
      end
      key_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      check("stall_no_key", 32'(cur_value), 32'd0);
      exp_tok(2'd0, 11'd7); exp_tok(2'd1, 11'd0);
      check_tokens("tok_stall");
      press(K_CLR);

      // operand limit
      press(4'd1); press(K_ADD); press(4'd2); press(K_ADD); press(4'd3);
      press(K_ADD);
      check("err_3rd_op", 32'(err), 32'd1);
      check("no_emit_3rd_op", 32'(out_valid), 32'd0);
      press(K_EQ);
      wait_idle();
      exp_tok(2'd0, 11'd1); exp_tok(2'd1, 11'd0);
      exp_tok(2'd0, 11'd2); exp_tok(2'd1, 11'd0);
      exp_tok(2'd0, 11'd3); exp_tok(2'd2, 11'd0);
      check_tokens("tok_limit");
      // operand count was cleared by EQ, so two more operators are allowed
      press(4'd4); press(K_ADD);
      check("opcnt_reset_1", 32'(err), 32'd0);
      press(4'd4); press(K_ADD);
      check("opcnt_reset_2", 32'(err), 32'd0);
      wait_idle();
      exp_tok(2'd0, 11'd4); exp_tok(2'd1, 11'd0);
      exp_tok(2'd0, 11'd4); exp_tok(2'd1, 11'd0);
      check_tokens("tok_opcnt");
      press(K_CLR);

      // empty-entry cases
      press(K_ADD);
      check("err_add_empty", 32'(err), 32'd1);
      press(K_EQ);
      check("err_eq_empty", 32'(err), 32'd1);
      press(K_BKSP);
      check("bksp_empty_no_err", 32'(err), 32'd0);
      press(4'd5); press(K_ADD); press(K_EQ);
      check("eq_after_op_ok", 32'(err), 32'd0);
      wait_idle();
      exp_tok(2'd0, 11'd5); exp_tok(2'd1, 11'd0);
      exp_tok(2'd0, 11'd0); exp_tok(2'd2, 11'd0);
      check_tokens("tok_empty_eq");
      press(4'd7); press(K_ADD); press(K_NEG);
      check("neg_zero_cur", 32'(cur_value), 32'd0);
      press(K_EQ);
      wait_idle();
      exp_tok(2'd0, 11'd7); exp_tok(2'd1, 11'd0);
      exp_tok(2'd0, 11'd0); exp_tok(2'd2, 11'd0);
      check_tokens("tok_neg_zero");

      // sign before digits, and sign clearing when backspaced to empty
      press(K_NEG); press(4'd2);
      check("cur_neg2", 32'(cur_value), 32'h7FE);
      press(K_BKSP); press(4'd3);
      check("sign_cleared", 32'(cur_value), 32'd3);
      press(K_CLR);

      // SUB operator code
      press(4'd8); press(K_SUB); press(4'd3); press(K_EQ);
      wait_idle();
      exp_tok(2'd0, 11'd8); exp_tok(2'd1, 11'd1);
      exp_tok(2'd0, 11'd3); exp_tok(2'd2, 11'd0);
      check_tokens("tok_sub");

      // reset while presenting the operator token
      out_ready = 1'b0;
      press(4'd6); press(K_ADD);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pre_rst_state", 32'(fsm_state), 32'd2);
      check("pre_rst_kind", 32'(out_kind), 32'd1);
      rst = 1'b1;
      tick();
      check("rst_emit_valid", 32'(out_valid), 32'd0);
      check("rst_emit_state", 32'(fsm_state), 32'd0);
      check("rst_emit_kready", 32'(key_ready), 32'd1);
      check("rst_emit_cur", 32'(cur_value), 32'd0);
      check("rst_emit_dc", 32'(digit_count), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      exp_tok(2'd0, 11'd6);
      check_tokens("tok_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
